// File: rtl/adc_spi_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_capture
// Purpose  : Triggers one conversion on an external SPI ADC per start request,
//            waits for BUSY to fall, clocks out DATA_BITS bits MSB first
//            (CPOL=0) and presents the word as a signed sample with a
//            1-cycle valid strobe. Aborts with a timeout strobe if BUSY never
//            falls.
// Ports    : clk, rst (async, active high)
//            start_i                 - 1-cycle request, honoured in IDLE only
//            adc_busy_i, adc_sdo_i   - ADC BUSY (asynchronous) and serial data
//            adc_convst_o, adc_cs_n_o, adc_sclk_o - ADC control / SPI outputs
//            sample_out_o            - last captured sample (held)
//            sample_valid_o          - sample_out_o updated this cycle
//            ready_o                 - high in IDLE only
//            timeout_err_o           - conversion aborted, BUSY never fell
//            overrange_o             - full-scale flag (ADC_OVERRANGE_EN only)
// Options  : `define ADC_OVERRANGE_EN adds overrange_o
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_capture #(
    parameter int CLK_DIV     = 4,
    parameter int DATA_BITS   = 24,
    parameter int CONVST_W    = 8,
    parameter int BUSY_IGN    = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 adc_busy_i,
    input  logic                 adc_sdo_i,
    output logic                 adc_convst_o,
    output logic                 adc_cs_n_o,
    output logic                 adc_sclk_o,
    output logic [DATA_BITS-1:0] sample_out_o,
    output logic                 sample_valid_o,
    output logic                 ready_o,
`ifdef ADC_OVERRANGE_EN
    output logic                 overrange_o,
`endif
    output logic                 timeout_err_o
);

    // One shared counter serves CONVST width, WAIT_BUSY timeout and the
    // SCLK half-period divider, so it is sized for the largest of the three.
    localparam int c_CNT_MAX = (TIMEOUT_CYC > CONVST_W) ?
                               ((TIMEOUT_CYC > CLK_DIV) ? TIMEOUT_CYC : CLK_DIV) :
                               ((CONVST_W > CLK_DIV) ? CONVST_W : CLK_DIV);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_BIT_W   = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONVST = 3'd1,
        S_WAIT   = 3'd2,
        S_SHIFT  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;
    logic [c_BIT_W-1:0]     bit_q, bit_d;
    logic                   sclk_q, sclk_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   sample_q, sample_d;
    logic                   busy_s1_q, busy_s2_q;
    logic                   w_last_bit;
`ifdef ADC_OVERRANGE_EN
    logic                   ovr_q, ovr_d;
`endif

    assign w_last_bit = (bit_q == c_BIT_W'(DATA_BITS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
            shreg_q   <= '0;
            sample_q  <= '0;
            busy_s1_q <= 1'b0;
            busy_s2_q <= 1'b0;
`ifdef ADC_OVERRANGE_EN
            ovr_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            shreg_q   <= shreg_d;
            sample_q  <= sample_d;
            busy_s1_q <= adc_busy_i;
            busy_s2_q <= busy_s1_q;
`ifdef ADC_OVERRANGE_EN
            ovr_q     <= ovr_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        sclk_d        = sclk_q;
        shreg_d       = shreg_q;
        sample_d      = sample_q;
        timeout_err_o = 1'b0;
`ifdef ADC_OVERRANGE_EN
        ovr_d         = ovr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CONVST;
                    cnt_d   = '0;
                end
            end
            S_CONVST: begin
                if (cnt_q == c_CNT_W'(CONVST_W - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            S_WAIT: begin
                // BUSY falling wins over a timeout landing on the same cycle.
                if ((cnt_q >= c_CNT_W'(BUSY_IGN)) && !busy_s2_q) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                end else if (cnt_q == c_CNT_W'(TIMEOUT_CYC)) begin
                    state_d       = S_IDLE;
                    timeout_err_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            S_SHIFT: begin
                // Leave once SCLK is back low after the final rising edge.
                if (!sclk_q && w_last_bit) begin
                    state_d  = S_DONE;
                    sample_d = shreg_q;
`ifdef ADC_OVERRANGE_EN
                    ovr_d = (shreg_q == {1'b0, {(DATA_BITS-1){1'b1}}}) ||
                            (shreg_q == {1'b1, {(DATA_BITS-1){1'b0}}});
`endif
                end else if (cnt_q == c_CNT_W'(CLK_DIV - 1)) begin
                    cnt_d  = '0;
                    sclk_d = !sclk_q;
                    if (!sclk_q) begin
                        // 0->1 transition: data has settled for CLK_DIV cycles.
                        shreg_d = {shreg_q[DATA_BITS-2:0], adc_sdo_i};
                        if (!w_last_bit) begin
                            bit_d = bit_q + c_BIT_W'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign adc_convst_o   = (state_q == S_CONVST);
    assign adc_cs_n_o     = (state_q != S_SHIFT);
    assign adc_sclk_o     = sclk_q;
    assign sample_out_o   = sample_q;
    assign sample_valid_o = (state_q == S_DONE);
    assign ready_o        = (state_q == S_IDLE);
`ifdef ADC_OVERRANGE_EN
    assign overrange_o    = ovr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_spi_capture
// Purpose  : Self-checking bench for adc_spi_capture. A behavioural ADC model
//            drives BUSY and SDO; expected strobe timing, captured words and
//            status flags are computed from the frame rules with arithmetic.
// Options  : honours `define ADC_OVERRANGE_EN
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_spi_capture;

    localparam int CLK_DIV     = 4;
    localparam int DATA_BITS   = 24;
    localparam int CONVST_W    = 8;
    localparam int BUSY_IGN    = 4;
    localparam int TIMEOUT_CYC = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        adc_busy_i;
    logic        adc_sdo_i;
    logic        adc_convst_o;
    logic        adc_cs_n_o;
    logic        adc_sclk_o;
    logic [23:0] sample_out_o;
    logic        sample_valid_o;
    logic        ready_o;
    logic        timeout_err_o;
`ifdef ADC_OVERRANGE_EN
    logic        overrange_o;
`endif

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [23:0] last_sample;

    always #5 clk = ~clk;

    adc_spi_capture #(
        .CLK_DIV    (CLK_DIV),
        .DATA_BITS  (DATA_BITS),
        .CONVST_W   (CONVST_W),
        .BUSY_IGN   (BUSY_IGN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .adc_busy_i    (adc_busy_i),
        .adc_sdo_i     (adc_sdo_i),
        .adc_convst_o  (adc_convst_o),
        .adc_cs_n_o    (adc_cs_n_o),
        .adc_sclk_o    (adc_sclk_o),
        .sample_out_o  (sample_out_o),
        .sample_valid_o(sample_valid_o),
        .ready_o       (ready_o),
`ifdef ADC_OVERRANGE_EN
        .overrange_o   (overrange_o),
`endif
        .timeout_err_o (timeout_err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One conversion. BUSY rises with start and falls d cycles after CONVST
    // ends; SDO presents the next bit after every observed SCLK rise.
    // poke: extra start pulses in CONVST, WAIT_BUSY, SHIFT and DONE.
    // abort_rise > 0: return right after that many SCLK rises.
    task automatic frame(input logic [23:0] w, input int d, input bit poke,
                         input int abort_rise, input string tag);
        int          t_wait, e_cyc, k, rises, nvalid, vcyc, nconv, nto, nready;
        logic        prev_sclk, vready;
        logic [23:0] vsample;
        logic        vovr;
        k      = CONVST_W + d;
        // BUSY low becomes visible to the FSM two edges after it is driven.
        t_wait = (((d + 1) > BUSY_IGN) ? (d + 1) : BUSY_IGN) + 1;
        e_cyc  = 1 + CONVST_W + t_wait + 2 * CLK_DIV * DATA_BITS + 1;
        rises = 0; nvalid = 0; vcyc = -1; nconv = 0; nto = 0; nready = 0;
        prev_sclk = 1'b0; vready = 1'b1; vsample = '0; vovr = 1'b0;
        adc_sdo_i = w[23];
        for (int cyc = 0; cyc <= e_cyc + 4; cyc++) begin
            if (adc_sclk_o && !prev_sclk) begin
                rises++;
                if (rises < 24) adc_sdo_i = w[23 - rises];
            end
            prev_sclk = adc_sclk_o;
            if (adc_convst_o)  nconv++;
            if (timeout_err_o) nto++;
            if (ready_o)       nready++;
            if (sample_valid_o) begin
                nvalid++;
                vcyc    = cyc;
                vsample = sample_out_o;
                vready  = ready_o;
`ifdef ADC_OVERRANGE_EN
                vovr    = overrange_o;
`endif
            end
            if (abort_rise > 0 && rises == abort_rise) return;
            start_i = (cyc == 0) ||
                      (poke && (cyc == 3 || cyc == CONVST_W + 2 ||
                                cyc == CONVST_W + 1 + t_wait + 50 || cyc == e_cyc));
            if (cyc == 0) adc_busy_i = 1'b1;
            if (cyc == k) adc_busy_i = 1'b0;
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        if (abort_rise > 0) check({tag, ".abort_reached"}, rises, abort_rise);
        check({tag, ".valid_count"}, nvalid, 1);
        check({tag, ".valid_cycle"}, vcyc, e_cyc);
        check({tag, ".sample"}, vsample, w);
        check({tag, ".sclk_rises"}, rises, DATA_BITS);
        check({tag, ".convst_cycles"}, nconv, CONVST_W);
        check({tag, ".timeout_none"}, nto, 0);
        check({tag, ".ready_in_done"}, vready, 0);
        check({tag, ".ready_cycles"}, nready, 5);
        check({tag, ".sample_held"}, sample_out_o, w);
        check({tag, ".cs_n_idle"}, adc_cs_n_o, 1);
`ifdef ADC_OVERRANGE_EN
        check({tag, ".overrange"}, vovr, (w == 24'h7FFFFF) || (w == 24'h800000));
        check({tag, ".overrange_held"}, overrange_o, vovr);
`endif
        last_sample = w;
    endtask

    // BUSY stuck high: expect the abort strobe after CONVST plus the full
    // timeout window, with no sample update.
    task automatic timeout_run();
        int   nto, tcyc, nvalid;
        logic rdy_after;
        nto = 0; tcyc = -10; nvalid = 0; rdy_after = 1'b0;
        for (int cyc = 0; cyc <= 1 + CONVST_W + TIMEOUT_CYC + 3; cyc++) begin
            if (timeout_err_o) begin
                nto++;
                tcyc = cyc;
            end
            if (cyc == tcyc + 1) rdy_after = ready_o;
            if (sample_valid_o) nvalid++;
            start_i    = (cyc == 0);
            adc_busy_i = 1'b1;
            @(posedge clk); #1;
        end
        start_i    = 1'b0;
        adc_busy_i = 1'b0;
        check("timeout.count", nto, 1);
        check("timeout.cycle", tcyc, 1 + CONVST_W + TIMEOUT_CYC);
        check("timeout.no_valid", nvalid, 0);
        check("timeout.sample_kept", sample_out_o, last_sample);
        check("timeout.ready_after", rdy_after, 1);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; adc_busy_i = 1'b0; adc_sdo_i = 1'b0;
        last_sample = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.cs_n", adc_cs_n_o, 1);
        check("reset.sclk", adc_sclk_o, 0);
        check("reset.convst", adc_convst_o, 0);
        check("reset.sample", sample_out_o, 0);
        check("reset.valid", sample_valid_o, 0);
        check("reset.timeout", timeout_err_o, 0);
        check("reset.ready", ready_o, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        frame(24'hAACCCC, 20, 1'b0, 0, "nominal");

        // Reset in the middle of SHIFT after bit 10.
        frame(24'h123456, 12, 1'b0, 10, "partial");
        rst = 1'b1;
        #1;
        check("midrst.cs_n", adc_cs_n_o, 1);
        check("midrst.sclk", adc_sclk_o, 0);
        check("midrst.convst", adc_convst_o, 0);
        check("midrst.sample", sample_out_o, 0);
        check("midrst.ready", ready_o, 1);
        last_sample = '0;
        @(posedge clk); #1;
        rst = 1'b0; adc_busy_i = 1'b0;
        @(posedge clk); #1;
        frame(24'h5A3C96, 6, 1'b0, 0, "after_reset");

        frame(24'h800001, 0, 1'b0, 0, "sign");
        check("sign.value", 32'($signed(sample_out_o)), 32'(-8388607));

        timeout_run();

        frame(24'h0F0F0F, 15, 1'b1, 0, "ignore_start");
        frame(24'h7FFFFF, 3, 1'b0, 0, "fullscale_pos");
        frame(24'h000123, 9, 1'b0, 0, "small");
        frame(24'h800000, 1, 1'b0, 0, "fullscale_neg");

        for (int i = 0; i < 4; i++) begin
            frame(24'($urandom), int'($urandom_range(0, 40)), 1'b0, 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
